taglist_player: RTL
===================

# taglist_player

Sequence player that drives the sequence ROM from the tag list. On a play request for sequence number N it reads tag-list RAM entry N, validates it, then steps the ROM address from the entry's first address to its last address, once or looping. It sits between the tag-list RAM, written by the tag-list generator after the ROM scan, and the ROM read port. It is the sole reader of the tag-list RAM.

## Interface
Parameters:
- STEP_TICKS, 1: clock cycles each ROM address is held (≥1).

Ports (clock and reset first):
- clk_1KHz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- list_ready  in  1  tag-list build complete; RAM contents valid.
- list_count  in  7  number of valid tag-list entries (0–127).
- play_req  in  1  level; sampled only in IDLE.
- play_seq  in  7  requested sequence number.
- play_loop  in  1  latched with request; 1 = repeat until abort.
- abort  in  1  stop playback; highest priority.
- play_ack  out  1  one-cycle pulse: request accepted.
- play_err  out  1  one-cycle pulse: request rejected or entry invalid.
- ram_rd_en  out  1  tag-list RAM read enable.
- ram_rd_addr  out  7  tag-list RAM address (= sequence number).
- ram_rd_data  in  32  entry: [31:28]=0, [27:21]=seqNum, [20:11]=first, [10:1]=last, [0]=end-of-ROM flag.
- rom_addr  out  10  ROM address being played.
- rom_valid  out  1  rom_addr is valid.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse: non-loop playback finished.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, DONE, ERR.
- IDLE: when play_req=1, the request is checked:
  - It is accepted if list_ready=1 and play_seq < list_count; the next state is FETCH.
  - Otherwise the next state is ERR.
  - play_seq and play_loop are latched on acceptance.
- FETCH: ram_rd_en=1, ram_rd_addr=latched seq, play_ack=1. The next state is LOAD.
- LOAD: ram_rd_data is valid this cycle (read latency 1) and is checked.
  - The entry is valid if [31:28]=0, [27:21]=latched seq, and first ≤ last.
  - If valid: first and last are registered, rom_addr←first, tick counter←0, and the next state is PLAY.
  - If invalid: the next state is ERR.
- PLAY: rom_valid=1. The tick counter counts 0..STEP_TICKS-1. At the terminal tick:
  - If rom_addr < last: rom_addr+1.
  - If rom_addr = last and loop=1: rom_addr←first.
  - If rom_addr = last and loop=0: go to DONE.
- DONE: done=1, rom_valid=0; next state IDLE.
- ERR: play_err=1; next state IDLE.
- abort=1 in any state other than IDLE: next state is IDLE, rom_valid=0, and no done/err/ack pulse is issued that cycle. abort in IDLE has no effect.
- play_req outside IDLE is ignored, not queued.
- Arithmetic is 10-bit unsigned. rom_addr never exceeds last, so there is no wrap. first = last plays a single address.
- The end-of-ROM flag [0] is not used for playback.

## Timing
- Reset values (the cycle after reset high): state IDLE; play_ack, play_err, ram_rd_en, rom_valid, busy, done = 0; ram_rd_addr = 0; rom_addr = 0.
- reset mid-playback: the same values apply next cycle, and reset overrides abort and requests.
- Request sampled at edge t:
  - FETCH during cycle t+1, with play_ack and ram_rd_en asserted.
  - LOAD during t+2.
  - First rom_valid=1 with rom_addr=first during t+3.
- Each address is held STEP_TICKS cycles. A non-loop sequence of L=last−first+1 addresses has rom_valid high for L·STEP_TICKS cycles, followed by a 1-cycle done pulse, and IDLE the cycle after.
- Rejected request at t: play_err during t+1, IDLE at t+2.
- Invalid entry: play_err during t+3, no rom_valid.
- Back-to-back: a new request is sampled in the first IDLE cycle after DONE or ERR.
- Loop wrap: the cycle after last's terminal tick shows rom_addr=first, with no gap in rom_valid.

## Test plan
- list_count=5, entry 2 = {0,7'd2,10'd10,10'd13,0}, STEP_TICKS=1, play_req seq=2 loop=0 → ack at t+1; rom_addr 10,11,12,13 on t+3..t+6; done at t+7; busy low at t+8.
- list_ready=0 or play_seq=5 with list_count=5 → play_err pulse at t+1, no ram_rd_en, no rom_valid.
- Entry 3 holds seqNum field 4 (mismatch) → ack, LOAD, then play_err at t+3; rom_valid never asserted.
- Loop mode on entry {first=20,last=21}, STEP_TICKS=2 → rom_addr 20,20,21,21,20,20,… continuously; abort asserted mid-hold → next cycle IDLE, rom_valid=0, no done.
- Single-address entry first=last=0 → one cycle rom_addr=0 valid, then done.
- reset asserted during PLAY at rom_addr=12 → next cycle all outputs 0; play_req held high during PLAY is ignored until IDLE.

Source files
------------

// File: rtl/taglist_player_if.sv
// rtl/taglist_player_if.sv - request, tag-list RAM and ROM-address signals of the sequence player
interface taglist_player_if;
   logic        list_ready;
   logic [6:0]  list_count;
   logic        play_req;
   logic [6:0]  play_seq;
   logic        play_loop;
   logic        abort;
   logic        play_ack;
   logic        play_err;
   logic        ram_rd_en;
   logic [6:0]  ram_rd_addr;
   logic [31:0] ram_rd_data;
   logic [9:0]  rom_addr;
   logic        rom_valid;
   logic        busy;
   logic        done;

   modport master (
      output list_ready, list_count, play_req, play_seq, play_loop, abort, ram_rd_data,
      input  play_ack, play_err, ram_rd_en, ram_rd_addr, rom_addr, rom_valid, busy, done
   );

   modport slave (
      input  list_ready, list_count, play_req, play_seq, play_loop, abort, ram_rd_data,
      output play_ack, play_err, ram_rd_en, ram_rd_addr, rom_addr, rom_valid, busy, done
   );
endinterface

// File: rtl/taglist_player.sv
// rtl/taglist_player.sv - plays a ROM address range looked up from the tag-list RAM
module taglist_player #(
   parameter int STEP_TICKS = 1
) (
   input logic             clk_1KHz,
   input logic             reset,
   taglist_player_if.slave bus
);
   localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE, ERR} state_t;

   state_t        state;
   logic          loop_q;
   logic [9:0]    first_q;
   logic [9:0]    last_q;
   logic [TW-1:0] tick;

   logic [9:0] ent_first;
   logic [9:0] ent_last;
   logic       ent_ok;
   logic       req_ok;
   logic       unused_eor;

   assign ent_first  = bus.ram_rd_data[20:11];
   assign ent_last   = bus.ram_rd_data[10:1];
   assign unused_eor = bus.ram_rd_data[0];
   // ram_rd_addr doubles as the latched sequence number for the seqNum check
   assign ent_ok = (bus.ram_rd_data[31:28] == 4'd0) &&
                   (bus.ram_rd_data[27:21] == bus.ram_rd_addr) &&
                   (ent_first <= ent_last);
   assign req_ok = bus.list_ready && (bus.play_seq < bus.list_count);

   always_ff @(posedge clk_1KHz) begin
      if (reset) begin
         state           <= IDLE;
         loop_q          <= 1'b0;
         first_q         <= '0;
         last_q          <= '0;
         tick            <= '0;
         bus.play_ack    <= 1'b0;
         bus.play_err    <= 1'b0;
         bus.ram_rd_en   <= 1'b0;
         bus.ram_rd_addr <= '0;
         bus.rom_addr    <= '0;
         bus.rom_valid   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
      end else begin
         bus.play_ack  <= 1'b0;
         bus.play_err  <= 1'b0;
         bus.ram_rd_en <= 1'b0;
         bus.done      <= 1'b0;
         if (state != IDLE && bus.abort) begin
            state         <= IDLE;
            bus.rom_valid <= 1'b0;
            bus.busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.play_req) begin
                     bus.busy <= 1'b1;
                     if (req_ok) begin
                        state           <= FETCH;
                        loop_q          <= bus.play_loop;
                        bus.ram_rd_addr <= bus.play_seq;
                        bus.ram_rd_en   <= 1'b1;
                        bus.play_ack    <= 1'b1;
                     end else begin
                        state        <= ERR;
                        bus.play_err <= 1'b1;
                     end
                  end
               end
               FETCH: state <= LOAD;
               LOAD: begin
                  if (ent_ok) begin
                     state         <= PLAY;
                     first_q       <= ent_first;
                     last_q        <= ent_last;
                     bus.rom_addr  <= ent_first;
                     bus.rom_valid <= 1'b1;
                     tick          <= '0;
                  end else begin
                     state        <= ERR;
                     bus.play_err <= 1'b1;
                  end
               end
               PLAY: begin
                  if (tick == TICK_LAST) begin
                     tick <= '0;
                     if (bus.rom_addr < last_q) begin
                        bus.rom_addr <= bus.rom_addr + 10'd1;
                     end else if (loop_q) begin
                        bus.rom_addr <= first_q;
                     end else begin
                        state         <= DONE;
                        bus.rom_valid <= 1'b0;
                        bus.done      <= 1'b1;
                     end
                  end else begin
                     tick <= tick + TW'(1);
                  end
               end
               DONE, ERR: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
               default: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
